// File: rtl/instr_fsm_pkg.sv
// Shared types and encodings for the instruction controller (instr_fsm).
// The optional illegal-instruction trap is enabled by defining INSTR_FSM_ILLEGAL_TRAP_EN.
package instr_fsm_pkg;

    // Primary opcodes (IR[15:13])
    localparam logic [2:0] OPC_MOV   = 3'b110;
    localparam logic [2:0] OPC_ALU   = 3'b101;

    // Secondary op field (IR[12:11]) for MOV-class instructions
    localparam logic [1:0] OP_MOVIMM = 2'b10;
    localparam logic [1:0] OP_MOVREG = 2'b00;

    // Secondary op field (IR[12:11]) for ALU-class instructions, doubles as aluop
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_CMP   = 2'b01;
    localparam logic [1:0] ALU_AND   = 2'b10;
    localparam logic [1:0] ALU_MVN   = 2'b11;

    // Writeback mux selections
    localparam logic [1:0] VSEL_C    = 2'b00;
    localparam logic [1:0] VSEL_IMM8 = 2'b10;

    // Controller states; ERROR only exists when the trap is compiled in
    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_GET_A  = 3'd2,
        S_GET_B  = 3'd3,
        S_ALU    = 3'd4,
        S_WR_REG = 3'd5,
`ifdef INSTR_FSM_ILLEGAL_TRAP_EN
        S_WR_IMM = 3'd6,
        S_ERROR  = 3'd7
`else
        S_WR_IMM = 3'd6
`endif
    } state_t;

endpackage

// File: rtl/instr_fsm_decode.sv
// Combinational field extraction from the latched instruction register.
// No state; every output is a pure slice or sign extension of the IR.
module instr_decode
    import instr_fsm_pkg::*;
#(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic [DW-1:0] i_ir,
    output logic [2:0]    o_opcode,
    output logic [1:0]    o_op,
    output logic [RW-1:0] o_rn,
    output logic [RW-1:0] o_rd,
    output logic [1:0]    o_sh,
    output logic [RW-1:0] o_rm,
    output logic [DW-1:0] o_sximm8
);

    assign o_opcode = i_ir[15:13];
    assign o_op     = i_ir[12:11];
    assign o_rn     = i_ir[8 +: RW];
    assign o_rd     = i_ir[5 +: RW];
    assign o_sh     = i_ir[4:3];
    assign o_rm     = i_ir[0 +: RW];
    // Sign-extend the 8-bit immediate to the full datapath width
    assign o_sximm8 = {{(DW-8){i_ir[7]}}, i_ir[7:0]};

endmodule

// File: rtl/instr_fsm.sv
// Instruction controller sitting in front of the 8x16 register file.
// Latches an instruction in WAIT, decodes it and walks the register file /
// datapath strobes through one micro-step per clock, raising w when idle.
// Optional: define INSTR_FSM_ILLEGAL_TRAP_EN to trap unsupported
// instructions in a sticky ERROR state with err = 1.
module instr_fsm
    import instr_fsm_pkg::*;
#(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s,
    input  logic          load_ir,
    input  logic [DW-1:0] instr,
    output logic          w,
    output logic [RW-1:0] readnum,
    output logic [RW-1:0] writenum,
    output logic          write,
    output logic          loada,
    output logic          loadb,
    output logic          loadc,
    output logic          loads,
    output logic          asel,
    output logic          bsel,
    output logic [1:0]    vsel,
    output logic [1:0]    shift,
    output logic [1:0]    aluop,
    output logic [DW-1:0] sximm8,
    output logic          err
);

    state_t        r_state;
    state_t        w_next;
    logic [DW-1:0] r_ir;

    logic          r_w;
    logic [RW-1:0] r_readnum;
    logic [RW-1:0] r_writenum;
    logic          r_write;
    logic          r_loada;
    logic          r_loadb;
    logic          r_loadc;
    logic          r_loads;
    logic          r_asel;
    logic [1:0]    r_vsel;
    logic [1:0]    r_shift;
    logic [1:0]    r_aluop;

    logic [2:0]    w_opcode;
    logic [1:0]    w_op;
    logic [RW-1:0] w_rn;
    logic [RW-1:0] w_rd;
    logic [1:0]    w_sh;
    logic [RW-1:0] w_rm;

    logic          w_is_movimm;
    logic          w_is_movreg;
    logic          w_is_alu;
    logic          w_is_mvn;
    logic          w_is_cmp;
    logic          w_needs_a;

    instr_decode #(
        .DW (DW),
        .RW (RW)
    ) u_decode (
        .i_ir     (r_ir),
        .o_opcode (w_opcode),
        .o_op     (w_op),
        .o_rn     (w_rn),
        .o_rd     (w_rd),
        .o_sh     (w_sh),
        .o_rm     (w_rm),
        .o_sximm8 (sximm8)
    );

    // Instruction class flags derived from the latched IR
    assign w_is_movimm = (w_opcode == OPC_MOV) && (w_op == OP_MOVIMM);
    assign w_is_movreg = (w_opcode == OPC_MOV) && (w_op == OP_MOVREG);
    assign w_is_alu    = (w_opcode == OPC_ALU);
    assign w_is_mvn    = w_is_alu && (w_op == ALU_MVN);
    assign w_is_cmp    = w_is_alu && (w_op == ALU_CMP);
    assign w_needs_a   = w_is_alu && ((w_op == ALU_ADD) || (w_op == ALU_CMP) || (w_op == ALU_AND));

    // Next-state selection from the current state and the decoded IR
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_WAIT: begin
                if (s) w_next = S_DECODE;
            end
            S_DECODE: begin
                if (w_is_movimm) begin
                    w_next = S_WR_IMM;
                end else if (w_is_movreg || w_is_mvn) begin
                    w_next = S_GET_B;
                end else if (w_needs_a) begin
                    w_next = S_GET_A;
                end else begin
`ifdef INSTR_FSM_ILLEGAL_TRAP_EN
                    w_next = S_ERROR;
`else
                    w_next = S_WAIT;
`endif
                end
            end
            S_GET_A:  w_next = S_GET_B;
            S_GET_B:  w_next = S_ALU;
            S_ALU:    w_next = w_is_cmp ? S_WAIT : S_WR_REG;
            S_WR_REG: w_next = S_WAIT;
            S_WR_IMM: w_next = S_WAIT;
`ifdef INSTR_FSM_ILLEGAL_TRAP_EN
            S_ERROR:  w_next = S_ERROR;
`endif
            default:  w_next = S_WAIT;
        endcase
    end

    // State, IR and registered Moore outputs; outputs are precomputed for the
    // state being entered so they line up with that state's cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_WAIT;
            r_ir       <= '0;
            r_w        <= 1'b1;
            r_readnum  <= '0;
            r_writenum <= '0;
            r_write    <= 1'b0;
            r_loada    <= 1'b0;
            r_loadb    <= 1'b0;
            r_loadc    <= 1'b0;
            r_loads    <= 1'b0;
            r_asel     <= 1'b0;
            r_vsel     <= VSEL_C;
            r_shift    <= 2'b00;
            r_aluop    <= 2'b00;
        end else begin
            r_state <= w_next;
            // IR only accepts a new word while idle
            if ((r_state == S_WAIT) && load_ir) r_ir <= instr;

            r_w        <= (w_next == S_WAIT);
            r_readnum  <= '0;
            r_writenum <= '0;
            r_write    <= 1'b0;
            r_loada    <= 1'b0;
            r_loadb    <= 1'b0;
            r_loadc    <= 1'b0;
            r_loads    <= 1'b0;
            r_asel     <= 1'b0;
            r_vsel     <= VSEL_C;
            r_shift    <= 2'b00;
            r_aluop    <= 2'b00;

            // IR only changes on WAIT->WAIT/DECODE, neither of which uses IR
            // fields, so the current decode is valid for the entered state.
            case (w_next)
                S_GET_A: begin
                    r_readnum <= w_rn;
                    r_loada   <= 1'b1;
                end
                S_GET_B: begin
                    r_readnum <= w_rm;
                    r_loadb   <= 1'b1;
                    r_shift   <= w_sh;
                end
                S_ALU: begin
                    r_shift <= w_sh;
                    r_asel  <= w_is_movreg || w_is_mvn;
                    r_aluop <= w_is_alu ? w_op : 2'b00;
                    r_loads <= w_is_cmp;
                    r_loadc <= !w_is_cmp;
                end
                S_WR_REG: begin
                    r_writenum <= w_rd;
                    r_vsel     <= VSEL_C;
                    r_write    <= 1'b1;
                end
                S_WR_IMM: begin
                    r_writenum <= w_rn;
                    r_vsel     <= VSEL_IMM8;
                    r_write    <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef INSTR_FSM_ILLEGAL_TRAP_EN
    logic r_err;

    // Sticky illegal-instruction flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_next == S_ERROR) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign w        = r_w;
    assign readnum  = r_readnum;
    assign writenum = r_writenum;
    assign write    = r_write;
    assign loada    = r_loada;
    assign loadb    = r_loadb;
    assign loadc    = r_loadc;
    assign loads    = r_loads;
    assign asel     = r_asel;
    assign bsel     = 1'b0;
    assign vsel     = r_vsel;
    assign shift    = r_shift;
    assign aluop    = r_aluop;

endmodule

// File: tb/tb_instr_fsm.sv
// Directed testbench for instr_fsm: walks each instruction class cycle by
// cycle and compares the full control word against hand-computed values.
module tb_instr_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic        s;
    logic        load_ir;
    logic [15:0] instr;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada, loadb, loadc, loads;
    logic        asel, bsel;
    logic [1:0]  vsel, shift, aluop;
    logic [15:0] sximm8;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    instr_fsm #(.DW(16), .RW(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .s        (s),
        .load_ir  (load_ir),
        .instr    (instr),
        .w        (w),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .bsel     (bsel),
        .vsel     (vsel),
        .shift    (shift),
        .aluop    (aluop),
        .sximm8   (sximm8),
        .err      (err)
    );

    always #5 clk = ~clk;

    logic [19:0] obs;
    assign obs = {w, readnum, writenum, write, loada, loadb, loadc, loads,
                  asel, bsel, vsel, shift, aluop};

    // Expected control word; bsel is always 0 in this ISA
    function automatic logic [19:0] mk(input logic ew, input logic [2:0] rn,
                                       input logic [2:0] wn, input logic wr,
                                       input logic la, input logic lb,
                                       input logic lc, input logic ls,
                                       input logic as, input logic [1:0] vs,
                                       input logic [1:0] sh, input logic [1:0] al);
        return {ew, rn, wn, wr, la, lb, lc, ls, as, 1'b0, vs, sh, al};
    endfunction

    logic [19:0] IDLE;
    logic [19:0] BUSY;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [19:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] exp);
        n_cmp++;
        assert (sximm8 === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, sximm8, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic exp);
        n_cmp++;
        assert (err === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, err, exp);
        end
    endtask

    // Load and start in the same WAIT cycle; returns one cycle into DECODE
    task automatic start(input logic [15:0] ins);
        load_ir = 1'b1;
        s       = 1'b1;
        instr   = ins;
        tick();
        load_ir = 1'b0;
        s       = 1'b0;
    endtask

    initial begin
        IDLE    = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        BUSY    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        reset   = 1'b1;
        s       = 1'b0;
        load_ir = 1'b0;
        instr   = 16'h0000;
        tick();
        tick();
        chk("reset_ctrl", IDLE);
        chk1("reset_err", 1'b0);
        chk16("reset_imm", 16'h0000);
        reset = 1'b0;

        // MOV R1,#5 ; a load_ir during DECODE must not touch IR
        start(16'hD105);
        chk("movi1_dec", BUSY);
        chk16("movi1_imm", 16'h0005);
        load_ir = 1'b1;
        instr   = 16'hD2FF;
        tick();
        load_ir = 1'b0;
        chk("movi1_wr", mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00));
        chk16("ir_hold", 16'h0005);
        tick();
        chk("movi1_done", IDLE);

        // MOV R2,#-1 loaded first, started later
        load_ir = 1'b1;
        instr   = 16'hD2FF;
        tick();
        load_ir = 1'b0;
        chk("load_only", IDLE);
        chk16("movi2_imm", 16'hFFFF);
        s = 1'b1;
        tick();
        s = 1'b0;
        chk("movi2_dec", BUSY);
        tick();
        chk("movi2_wr", mk(0, 0, 2, 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00));
        tick();
        chk("movi2_done", IDLE);

        // ADD R3,R1,R2 ; s pulsed mid-instruction is ignored
        start(16'hA162);
        chk("add_dec", BUSY);
        s = 1'b1;
        tick();
        s = 1'b0;
        chk("add_geta", mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        tick();
        chk("add_getb", mk(0, 2, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        tick();
        chk("add_alu", mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00));
        tick();
        chk("add_wr", mk(0, 0, 3, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        tick();
        chk("add_done", IDLE);

        // CMP R1,R2,LSL#1 ; status only, no write
        start(16'hA90A);
        chk("cmp_dec", BUSY);
        tick();
        chk("cmp_geta", mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        tick();
        chk("cmp_getb", mk(0, 2, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b00));
        tick();
        chk("cmp_alu", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b01));
        tick();
        chk("cmp_done", IDLE);

        // MVN R7,R1 ; GET_A skipped
        start(16'hB8E1);
        chk("mvn_dec", BUSY);
        tick();
        chk("mvn_getb", mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        tick();
        chk("mvn_alu", mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b11));
        tick();
        chk("mvn_wr", mk(0, 0, 7, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        tick();
        chk("mvn_done", IDLE);

        // MOV R7,R1,LSL#1 ; asel forces A to zero, aluop 00
        start(16'hC0E9);
        chk("movr_dec", BUSY);
        tick();
        chk("movr_getb", mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b00));
        tick();
        chk("movr_alu", mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 2'b01, 2'b00));
        tick();
        chk("movr_wr", mk(0, 0, 7, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        tick();
        chk("movr_done", IDLE);

        // AND R3,R1,R2
        start(16'hB162);
        tick();
        chk("and_geta", mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        tick();
        tick();
        chk("and_alu", mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b10));
        tick();
        chk("and_wr", mk(0, 0, 3, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        tick();
        chk("and_done", IDLE);

        // Reset during GET_B of an ADD
        start(16'hA162);
        tick();
        tick();
        chk("rst_getb", mk(0, 2, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid", IDLE);
        chk16("rst_ir", 16'h0000);
        tick();
        chk("rst_after", IDLE);

        // Illegal opcode 111
        start(16'hE0AB);
        chk("ill_dec", BUSY);
        chk16("ill_imm", 16'hFFAB);
        tick();
`ifdef INSTR_FSM_ILLEGAL_TRAP_EN
        chk("ill_err_state", BUSY);
        chk1("ill_err_flag", 1'b1);
        for (int i = 0; i < 10; i++) begin
            s = i[0];
            tick();
            chk("ill_sticky", BUSY);
            chk1("ill_sticky_err", 1'b1);
        end
        s     = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("ill_reset", IDLE);
        chk1("ill_reset_err", 1'b0);
`else
        chk("ill_back", IDLE);
        chk1("ill_err", 1'b0);
        tick();
        chk("ill_idle", IDLE);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
